// File: rtl/icache_refill.sv
// Direct-mapped instruction cache placed in front of the fetch stage.
// A lookup is combinational from FE_PC. A miss refills the whole line over a
// req/gnt/beat handshake. The block also reports misaligned fetches and
// faulted lines.
module icache_refill #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] FE_PC,
  input  logic        FE_REQ,
  input  logic        FLUSH,
  output logic        ICACHE_R,
  output logic [31:0] FE_INSTRUCTION,
  output logic        ICACHE_IAM,
  output logic        ICACHE_IAF,
  output logic        MEM_RD_REQ,
  output logic [63:0] MEM_RD_ADDR,
  input  logic        MEM_RD_GNT,
  input  logic        MEM_RD_VALID,
  input  logic [31:0] MEM_RD_DATA,
  input  logic        MEM_RD_ERR
);
  localparam int WW  = $clog2(LINE_WORDS);
  localparam int IW  = $clog2(LINES);
  localparam int OFF = WW + 2;
  localparam int TW  = 64 - OFF - IW;
  localparam int LW  = 64 - OFF;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, FILL, FAULT} state_t;
  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*LINE_WORDS];

  // The latched line address carries both the refill index and the refill tag.
  // After an error it also identifies the faulted line.
  logic [LW-1:0] miss_line;
  logic [WW-1:0] cnt;
  logic          err, flush_pending, miss;

  logic [WW-1:0] pc_word;
  logic [IW-1:0] pc_idx, miss_idx;
  logic [TW-1:0] pc_tag, miss_tag;
  logic [LW-1:0] pc_line;
  logic          hit, beat, last_beat, err_eff, flush_eff;

  assign pc_word   = FE_PC[OFF-1:2];
  assign pc_idx    = FE_PC[OFF+IW-1:OFF];
  assign pc_tag    = FE_PC[63:OFF+IW];
  assign pc_line   = FE_PC[63:OFF];
  assign miss_idx  = miss_line[IW-1:0];
  assign miss_tag  = miss_line[LW-1:IW];

  assign ICACHE_IAM = (FE_PC[1:0] != 2'b00);
  assign hit        = FE_REQ && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag) && !ICACHE_IAM;
  assign beat       = (state == FILL) && MEM_RD_VALID;
  assign last_beat  = beat && (cnt == WW'(LINE_WORDS - 1));
  // The current beat's error and a same-cycle flush also decide the fate of the line.
  assign err_eff    = err | MEM_RD_ERR;
  assign flush_eff  = flush_pending | FLUSH;

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and all fetch/memory-side outputs.
  always_comb begin
    state_nxt      = state;
    ICACHE_R       = 1'b0;
    FE_INSTRUCTION = 32'h0;
    ICACHE_IAF     = 1'b0;
    MEM_RD_REQ     = 1'b0;
    MEM_RD_ADDR    = 64'h0;
    miss           = 1'b0;
    case (state)
      IDLE: begin
        if (FE_REQ) begin
          if (ICACHE_IAM) begin
            ICACHE_R       = 1'b1;
            FE_INSTRUCTION = NOP;
          end else if (hit) begin
            ICACHE_R       = 1'b1;
            FE_INSTRUCTION = data_mem[{pc_idx, pc_word}];
          end else begin
            miss      = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        MEM_RD_REQ  = 1'b1;
        MEM_RD_ADDR = {miss_line, {OFF{1'b0}}};
        if (MEM_RD_GNT) state_nxt = FILL;
      end
      FILL: begin
        if (last_beat) state_nxt = err_eff ? FAULT : IDLE;
      end
      FAULT: begin
        if (pc_line == miss_line) begin
          ICACHE_R       = 1'b1;
          ICACHE_IAF     = 1'b1;
          FE_INSTRUCTION = NOP;
        end
        if ((pc_line != miss_line) || FLUSH) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      ICACHE_R       = 1'b0;
      FE_INSTRUCTION = 32'h0;
      ICACHE_IAF     = 1'b0;
      MEM_RD_REQ     = 1'b0;
      MEM_RD_ADDR    = 64'h0;
      miss           = 1'b0;
    end
  end

  // Refill bookkeeping: latched line, beat counter, sticky error, flush and valid bits.
  always_ff @(posedge CLK) begin
    if (reset) begin
      valid         <= '0;
      miss_line     <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      if (miss) begin
        miss_line <= pc_line;
        cnt       <= '0;
        err       <= 1'b0;
      end
      if ((state == REQ) && MEM_RD_GNT) cnt <= '0;
      if (beat) begin
        cnt <= cnt + 1'b1;
        if (MEM_RD_ERR) err <= 1'b1;
      end
      if (((state == REQ) || (state == FILL)) && FLUSH) flush_pending <= 1'b1;
      if ((state != IDLE) && (state_nxt == IDLE)) flush_pending <= 1'b0;
      // The old occupant of the index is dropped whether or not the new line installs.
      if (FLUSH)          valid           <= '0;
      else if (last_beat) valid[miss_idx] <= !err_eff && !flush_eff;
    end
  end

  // Data and tag arrays; written only by refill beats, never reset.
  always_ff @(posedge CLK) begin
    if (!reset && beat)      data_mem[{miss_idx, cnt}] <= MEM_RD_DATA;
    if (!reset && last_beat) tag_mem[miss_idx]         <= miss_tag;
  end
endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill. It keeps a line-level reference model of
// the cache contents and the refill progress, and compares it against the DUT
// outputs on every cycle.
module tb_icache_refill;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] FE_PC = 64'h0;
  logic        FE_REQ = 1'b0, FLUSH = 1'b0;
  logic        ICACHE_R, ICACHE_IAM, ICACHE_IAF, MEM_RD_REQ;
  logic [31:0] FE_INSTRUCTION;
  logic [63:0] MEM_RD_ADDR;
  logic        MEM_RD_GNT = 1'b0, MEM_RD_VALID = 1'b0, MEM_RD_ERR = 1'b0;
  logic [31:0] MEM_RD_DATA = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  icache_refill #(.LINES(64), .LINE_WORDS(4)) dut (
    .CLK(clk), .reset(reset), .FE_PC(FE_PC), .FE_REQ(FE_REQ), .FLUSH(FLUSH),
    .ICACHE_R(ICACHE_R), .FE_INSTRUCTION(FE_INSTRUCTION), .ICACHE_IAM(ICACHE_IAM),
    .ICACHE_IAF(ICACHE_IAF), .MEM_RD_REQ(MEM_RD_REQ), .MEM_RD_ADDR(MEM_RD_ADDR),
    .MEM_RD_GNT(MEM_RD_GNT), .MEM_RD_VALID(MEM_RD_VALID), .MEM_RD_DATA(MEM_RD_DATA),
    .MEM_RD_ERR(MEM_RD_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The cache is held as a table of installed line addresses and their words.
  // The refill is tracked as a phase: 0 idle, 1 awaiting grant, 2 collecting
  // beats, 3 reporting a faulted line.
  bit          started = 0;
  bit          m_valid [64];
  logic [63:0] m_line  [64];
  logic [31:0] m_words [64][4];
  int          phase = 0;
  logic [63:0] m_addr = 64'h0;
  logic [31:0] beats [$];
  bit          m_err = 0, m_flush = 0;

  function automatic bit model_hit(input logic [63:0] pc);
    int idx = int'(pc[9:4]);
    return m_valid[idx] && (m_line[idx] == (pc & ~64'hF));
  endfunction

  // Advance the model at each edge using the inputs the DUT samples there.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 0;
      phase = 0; m_err = 0; m_flush = 0; beats.delete(); started = 1;
    end else begin
      int idx;
      case (phase)
        0: if (FE_REQ && FE_PC[1:0] == 2'b00 && !model_hit(FE_PC)) begin
             phase = 1; m_addr = FE_PC & ~64'hF; beats.delete(); m_err = 0;
           end
        1: begin
             if (FLUSH) m_flush = 1;
             if (MEM_RD_GNT) phase = 2;
           end
        2: begin
             if (FLUSH) m_flush = 1;
             if (MEM_RD_VALID) begin
               beats.push_back(MEM_RD_DATA);
               if (MEM_RD_ERR) m_err = 1;
               if (beats.size() == 4) begin
                 idx = int'(m_addr[9:4]);
                 m_valid[idx] = !m_err && !m_flush;
                 m_line[idx]  = m_addr;
                 for (int w = 0; w < 4; w++) m_words[idx][w] = beats[w];
                 if (m_err) phase = 3;
                 else begin phase = 0; m_flush = 0; end
               end
             end
           end
        3: if (((FE_PC & ~64'hF) != m_addr) || FLUSH) begin phase = 0; m_flush = 0; end
        default: phase = 0;
      endcase
      if (FLUSH) for (int i = 0; i < 64; i++) m_valid[i] = 0;
    end
  end

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic        e_r, e_iaf, e_req;
      logic [31:0] e_i;
      logic [63:0] e_addr;
      e_r = 0; e_iaf = 0; e_req = 0; e_i = 32'h0; e_addr = 64'h0;
      if (!reset) begin
        case (phase)
          0: if (FE_REQ) begin
               if (FE_PC[1:0] != 2'b00) begin e_r = 1; e_i = NOP; end
               else if (model_hit(FE_PC)) begin
                 e_r = 1; e_i = m_words[int'(FE_PC[9:4])][int'(FE_PC[3:2])];
               end
             end
          1: begin e_req = 1; e_addr = m_addr; end
          3: if ((FE_PC & ~64'hF) == m_addr) begin e_r = 1; e_iaf = 1; e_i = NOP; end
          default: ;
        endcase
      end
      chk("model_r",   {63'h0, ICACHE_R},   {63'h0, e_r});
      chk("model_iaf", {63'h0, ICACHE_IAF}, {63'h0, e_iaf});
      chk("model_req", {63'h0, MEM_RD_REQ}, {63'h0, e_req});
      chk("model_iam", {63'h0, ICACHE_IAM}, {63'h0, (FE_PC[1:0] != 2'b00)});
      if (e_r || reset)   chk("model_instr", {32'h0, FE_INSTRUCTION}, {32'h0, e_i});
      if (e_req || reset) chk("model_addr", MEM_RD_ADDR, e_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait for the line request, check its address, grant it, then return n beats.
  task automatic refill(input logic [63:0] addr, input logic [31:0] base, input int n,
                        input int err_beat, input int flush_beat);
    bit got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (MEM_RD_REQ) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL req_timeout: MEM_RD_REQ never rose for %h", addr);
      return;
    end
    chk("req_addr", MEM_RD_ADDR, addr);
    MEM_RD_GNT = 1;
    tick();
    MEM_RD_GNT = 0;
    for (int b = 0; b < n; b++) begin
      MEM_RD_VALID = 1; MEM_RD_DATA = base + b;
      MEM_RD_ERR = (b == err_beat); FLUSH = (b == flush_beat);
      tick();
    end
    MEM_RD_VALID = 0; MEM_RD_ERR = 0; FLUSH = 0;
  endtask

  task automatic fetch(input logic [63:0] pc);
    FE_PC = pc; FE_REQ = 1;
    @(negedge clk);
  endtask

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_r", {63'h0, ICACHE_R}, 64'h0);
    chk("rst_req", {63'h0, MEM_RD_REQ}, 64'h0);
    chk("rst_instr", {32'h0, FE_INSTRUCTION}, 64'h0);
    tick();
    reset = 0;

    // Cold miss, fill, then zero-latency hits.
    fetch(64'h1000);
    chk("cold_miss_r", {63'h0, ICACHE_R}, 64'h0);
    refill(64'h1000, 32'hA0, 4, -1, -1);
    @(negedge clk);
    chk("hit_w0", {31'h0, ICACHE_R, FE_INSTRUCTION}, {31'h0, 1'b1, 32'hA0});
    fetch(64'h100C);
    chk("hit_w3", {31'h0, ICACHE_R, FE_INSTRUCTION}, {31'h0, 1'b1, 32'hA3});

    // Misaligned fetch returns a nop and never requests memory.
    fetch(64'h1002);
    chk("iam", {62'h0, ICACHE_IAM, ICACHE_R}, 64'h3);
    chk("iam_nop", {32'h0, FE_INSTRUCTION}, {32'h0, NOP});
    tick(); @(negedge clk);
    chk("iam_noreq", {63'h0, MEM_RD_REQ}, 64'h0);

    // Conflict on index 0: 0x1400 evicts 0x1000.
    fetch(64'h1400);
    refill(64'h1400, 32'hB0, 4, -1, -1);
    @(negedge clk);
    chk("conflict_hit", {32'h0, FE_INSTRUCTION}, 64'hB0);
    fetch(64'h1000);
    chk("conflict_miss", {63'h0, ICACHE_R}, 64'h0);
    refill(64'h1000, 32'hA0, 4, -1, -1);
    @(negedge clk);
    chk("refetch_hit", {32'h0, FE_INSTRUCTION}, 64'hA0);

    // Bus error on beat 2 leaves a faulted line.
    fetch(64'h1800);
    refill(64'h1800, 32'hF0, 4, 2, -1);
    @(negedge clk);
    chk("fault_iaf", {62'h0, ICACHE_IAF, ICACHE_R}, 64'h3);
    fetch(64'h1804);
    chk("fault_line", {63'h0, ICACHE_IAF}, 64'h1);
    fetch(64'h2000);
    chk("fault_leave", {63'h0, ICACHE_IAF}, 64'h0);
    refill(64'h2000, 32'hC0, 4, -1, -1);
    @(negedge clk);
    chk("after_fault_hit", {32'h0, FE_INSTRUCTION}, 64'hC0);
    fetch(64'h1800);
    chk("fault_line_invalid", {63'h0, ICACHE_R}, 64'h0);
    refill(64'h1800, 32'h50, 4, -1, -1);

    // Flush during fill drains beats but does not validate the line.
    fetch(64'h3000);
    refill(64'h3000, 32'hD0, 4, -1, 1);
    @(negedge clk);
    chk("flush_fill_miss", {63'h0, ICACHE_R}, 64'h0);
    refill(64'h3000, 32'hE0, 4, -1, -1);
    @(negedge clk);
    chk("refill_after_flush", {31'h0, ICACHE_R, FE_INSTRUCTION}, {31'h0, 1'b1, 32'hE0});
    // A flush in IDLE still lets this cycle's lookup hit. The next lookup misses.
    FLUSH = 1;
    tick();
    FLUSH = 0;
    @(negedge clk);
    chk("flush_idle_miss", {63'h0, ICACHE_R}, 64'h0);
    FE_REQ = 0;
    tick();

    // Reset in the middle of a fill.
    fetch(64'h1000);
    refill(64'h1000, 32'hA0, 2, -1, -1);
    reset = 1; MEM_RD_VALID = 1; MEM_RD_DATA = 32'h77;
    tick();
    reset = 0; FE_REQ = 0;
    @(negedge clk);
    chk("rst_fill_req", {63'h0, MEM_RD_REQ}, 64'h0);
    tick(); tick();
    MEM_RD_VALID = 0;
    fetch(64'h1000);
    chk("rst_fill_miss", {63'h0, ICACHE_R}, 64'h0);
    tick(); @(negedge clk);
    chk("rst_fill_req2", {63'h0, MEM_RD_REQ}, 64'h1);
    reset = 1; FE_REQ = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
